// File: rtl/dmem_bridge_pkg.sv
// Shared definitions for the MEM-stage data memory bridge: FSM state
// encoding, the fixed byte-select pattern and the default fault data.
package dmem_bridge_pkg;

    // Bridge FSM states. The encoding is fixed so that it matches the
    // constants used elsewhere in the core.
    typedef enum logic [1:0] {
        DMB_IDLE = 2'd0,
        DMB_REQ  = 2'd1,
        DMB_DONE = 2'd2
    } dmb_state_t;

    // Only full-word accesses are issued, so every byte lane is selected.
    localparam logic [3:0]  DMB_SEL_WORD     = 4'hF;

    // Load data returned for a faulted (misaligned or timed-out) access.
    localparam logic [31:0] DMB_ERR_DATA_DEF = 32'h0000_0000;

    // True when a byte address is not word aligned.
    function automatic logic dmb_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/dmem_bridge_timeout.sv
// Bus watchdog: counts cycles spent waiting for an acknowledge and flags
// the last permitted cycle. The owner stops counting before the counter
// could pass TIMEOUT-1, so it never wraps.
module dmb_timeout #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int W = $clog2(TIMEOUT + 1);

    logic [W-1:0] cnt;

    // Wait-cycle counter; clear has priority over counting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + W'(1);
        end
    end

    // Asserted during the final REQ cycle the bus is allowed.
    always_comb begin
        expire = (cnt == W'(TIMEOUT - 1));
    end

endmodule

// File: rtl/dmem_bridge.sv
// MEM-stage to Wishbone-classic data memory bridge. A single-cycle
// load/store from the pipeline becomes a registered bus cycle; the
// pipeline is held with mem_stall until the bus acknowledges (or the
// watchdog fires), and the result is then presented in DONE until the
// MEM stage advances.
module dmem_bridge
    import dmem_bridge_pkg::*;
#(
    parameter int          TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = DMB_ERR_DATA_DEF
) (
    input  logic        clk,
    input  logic        rst,
    // MEM-stage side
    input  logic        mem_ren,
    input  logic        mem_wen,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_dout,
    input  logic        mem_adv,
    output logic [31:0] mem_din,
    output logic        mem_stall,
    output logic        mem_err,
    output logic [31:0] mem_err_addr,
    // Bus side
    output logic        bus_cyc,
    output logic        bus_stb,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_sel,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);

    dmb_state_t  state, state_next;

    logic        acc;
    logic        mis;
    logic        launch;      // start a bus cycle at this edge
    logic        finish_ok;   // bus acknowledged at this edge
    logic        finish_tmo;  // watchdog gave up at this edge
    logic        mis_log;     // record a misaligned fault address
    logic        tmr_en;
    logic        expire;
    logic [31:0] rdata_q;
    logic        err_q;

    // Request decode. A store wins when both requests are raised, which
    // only matters for bus_we since both forms share the alignment check.
    always_comb begin
        acc = mem_ren | mem_wen;
        mis = acc & dmb_misaligned(mem_addr);
    end

    dmb_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clr    (launch),
        .en     (tmr_en),
        .expire (expire)
    );

    // State register; reset abandons any in-flight access silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= DMB_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and pipeline-facing outputs. mem_stall depends only on
    // state and the MEM-stage request, never on bus inputs, so the stall
    // path stays short. In REQ the stall is unconditional.
    always_comb begin
        state_next = state;
        mem_stall  = 1'b0;
        mem_err    = 1'b0;
        mem_din    = '0;
        launch     = 1'b0;
        finish_ok  = 1'b0;
        finish_tmo = 1'b0;
        mis_log    = 1'b0;
        tmr_en     = 1'b0;
        case (state)
            DMB_IDLE: begin
                if (mis) begin
                    // Faulted without touching the bus; the pipeline is
                    // not held, so the error is a same-cycle pulse.
                    mem_err = 1'b1;
                    mem_din = ERR_DATA;
                    mis_log = 1'b1;
                end else if (acc) begin
                    mem_stall  = 1'b1;
                    launch     = 1'b1;
                    state_next = DMB_REQ;
                end
            end
            DMB_REQ: begin
                mem_stall = 1'b1;
                tmr_en    = 1'b1;
                if (bus_ack) begin
                    finish_ok  = 1'b1;
                    state_next = DMB_DONE;
                end else if (expire) begin
                    finish_tmo = 1'b1;
                    state_next = DMB_DONE;
                end
            end
            DMB_DONE: begin
                // Result is held until the MEM stage actually moves on;
                // the still-present request is not reissued.
                mem_din = rdata_q;
                mem_err = err_q;
                if (mem_adv) begin
                    state_next = DMB_IDLE;
                end
            end
            default: begin
                state_next = DMB_IDLE;
            end
        endcase
    end

    // Registered bus request, captured result and fault bookkeeping.
    // Bus inputs are only looked at through finish_ok, which is REQ-only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_cyc      <= 1'b0;
            bus_we       <= 1'b0;
            bus_addr     <= '0;
            bus_wdata    <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            mem_err_addr <= '0;
        end else begin
            if (launch) begin
                bus_cyc   <= 1'b1;
                bus_we    <= mem_wen;
                bus_addr  <= {mem_addr[31:2], 2'b00};
                bus_wdata <= mem_dout;
            end
            if (finish_ok) begin
                bus_cyc <= 1'b0;
                err_q   <= 1'b0;
                if (!bus_we) begin
                    rdata_q <= bus_rdata;
                end
            end
            if (finish_tmo) begin
                bus_cyc      <= 1'b0;
                rdata_q      <= ERR_DATA;
                err_q        <= 1'b1;
                mem_err_addr <= bus_addr;
            end
            if (mis_log) begin
                mem_err_addr <= mem_addr;
            end
        end
    end

    // Strobe always mirrors the cycle signal; only whole words are moved.
    always_comb begin
        bus_stb = bus_cyc;
        bus_sel = DMB_SEL_WORD;
    end

endmodule
